// File: rtl/pwm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_pkg                                                                   |
// | Shared types, default widths and ramp step arithmetic for pwm sequencers. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package pwm_pkg;

  localparam int unsigned PWM_XLEN_DEF   = 8;
  localparam int unsigned PWM_STEP_W_DEF = 4;
  // Wide enough that cur+step never wraps for any supported XLEN.
  localparam int unsigned PWM_CALC_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RAMP = 2'd2
  } pwm_ramp_state_t;

  // Move cur toward tgt by at most stp, never overshooting in either direction.
  function automatic logic [PWM_CALC_W-1:0] pwm_sat_step(
    input logic [PWM_CALC_W-1:0] cur,
    input logic [PWM_CALC_W-1:0] tgt,
    input logic [PWM_CALC_W-1:0] stp
  );
    logic [PWM_CALC_W-1:0] res;
    res = cur;
    if (cur < tgt) begin
      res = ((tgt - cur) <= stp) ? tgt : cur + stp;
    end else if (cur > tgt) begin
      res = ((cur - tgt) <= stp) ? tgt : cur - stp;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_period_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_period_counter                                                        |
// | Tracks the pwm counter phase; flags the last cycle and first cycle.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pwm_period_counter #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] duty_cycle,
  output logic         boundary,
  output logic         period_start
);

  logic [W-1:0] pcnt_q;
  logic [W-1:0] pcnt_d;

  assign boundary     = (pcnt_q == duty_cycle);
  assign period_start = (pcnt_q == W'(1));

  always_comb begin
    pcnt_d = boundary ? W'(1) : pcnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= W'(1);
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_ramp_ctrl                                                             |
// | Ramps pwm amplitude toward a target, updating only on period boundaries. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned XLEN       = PWM_XLEN_DEF,
  parameter int unsigned STEP_W     = PWM_STEP_W_DEF,
  parameter int unsigned DEF_PERIOD = 2**XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [XLEN-1:0]   cfg_target,
  input  logic [XLEN:0]     cfg_period,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic              abort,
  output logic [XLEN-1:0]   ampl,
  output logic [XLEN:0]     duty_cycle,
  output logic              period_start,
  output logic              busy,
  output logic              done
);

  pwm_ramp_state_t   state_q,  state_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic [XLEN:0]     period_q, period_d;
  logic [STEP_W-1:0] step_q,   step_d;
  logic              abort_q,  abort_d;
  logic [XLEN-1:0]   ampl_q,   ampl_d;
  logic [XLEN:0]     duty_q,   duty_d;
  logic              done_q,   done_d;

  logic              boundary;
  logic              abort_now;
  logic [XLEN-1:0]   ampl_step;

  pwm_period_counter #(
    .W (XLEN + 1)
  ) u_pcnt (
    .clk          (clk),
    .rst          (rst),
    .duty_cycle   (duty_q),
    .boundary     (boundary),
    .period_start (period_start)
  );

  assign ampl_step = XLEN'(pwm_sat_step(PWM_CALC_W'(ampl_q),
                                        PWM_CALC_W'(target_q),
                                        PWM_CALC_W'(step_q)));
  // An abort raised in the boundary cycle itself still wins over the step.
  assign abort_now = abort_q | abort;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    period_d = period_q;
    step_d   = step_q;
    abort_d  = abort_q;
    ampl_d   = ampl_q;
    duty_d   = duty_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (cfg_valid) begin
          target_d = cfg_target;
          period_d = (cfg_period == '0) ? (XLEN+1)'(1) : cfg_period;
          step_d   = (cfg_step == '0) ? STEP_W'(1) : cfg_step;
          state_d  = ARM;
        end
      end
      ARM, RAMP: begin
        if (boundary) begin
          abort_d = 1'b0;
          if (abort_now) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ampl_d = ampl_step;
            if (state_q == ARM) begin
              duty_d = period_q;
            end
            if (ampl_step == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = RAMP;
            end
          end
        end else begin
          abort_d = abort_now;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      period_q <= '0;
      step_q   <= '0;
      abort_q  <= 1'b0;
      ampl_q   <= '0;
      duty_q   <= (XLEN+1)'(DEF_PERIOD);
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      period_q <= period_d;
      step_q   <= step_d;
      abort_q  <= abort_d;
      ampl_q   <= ampl_d;
      duty_q   <= duty_d;
      done_q   <= done_d;
    end
  end

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign ampl       = ampl_q;
  assign duty_cycle = duty_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pwm_ramp_ctrl                                                          |
// | Directed and random stimulus against a ramp-plan reference model.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pwm_ramp_ctrl;

  localparam int XLEN   = 8;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [XLEN-1:0]   cfg_target;
  logic [XLEN:0]     cfg_period;
  logic [STEP_W-1:0] cfg_step;
  logic              abort;
  logic [XLEN-1:0]   ampl;
  logic [XLEN:0]     duty_cycle;
  logic              period_start;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .XLEN       (XLEN),
    .STEP_W     (STEP_W),
    .DEF_PERIOD (256)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_target   (cfg_target),
    .cfg_period   (cfg_period),
    .cfg_step     (cfg_step),
    .abort        (abort),
    .ampl         (ampl),
    .duty_cycle   (duty_cycle),
    .period_start (period_start),
    .busy         (busy),
    .done         (done)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a ramp is a precomputed list of amplitudes, one per period.
  int m_pcnt, m_duty, m_ampl, m_new_period;
  bit m_active, m_first, m_abort, m_done;
  int m_plan[$];

  int cyc_n = 0;
  int last_ampl = 0;
  int seen_v[$];
  int seen_t[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic void model_reset();
    m_pcnt   = 1;
    m_duty   = 256;
    m_ampl   = 0;
    m_active = 0;
    m_first  = 0;
    m_abort  = 0;
    m_done   = 0;
    m_plan.delete();
  endfunction

  function automatic void model_edge(input bit r, input bit v, input bit ab,
                                     input int tgt, input int per, input int stp);
    bit bnd;
    int cur, s;
    if (r) begin
      model_reset();
      return;
    end
    bnd    = (m_pcnt == m_duty);
    m_pcnt = bnd ? 1 : m_pcnt + 1;
    m_done = 0;
    if (!m_active) begin
      if (v) begin
        s   = (stp == 0) ? 1 : stp;
        cur = m_ampl;
        m_plan.delete();
        do begin
          if (cur < tgt)      cur = (cur + s > tgt) ? tgt : cur + s;
          else if (cur > tgt) cur = (cur - s < tgt) ? tgt : cur - s;
          m_plan.push_back(cur);
        end while (cur != tgt);
        m_new_period = (per == 0) ? 1 : per;
        m_active = 1;
        m_first  = 1;
        m_abort  = 0;
      end
    end else if (bnd) begin
      if (m_abort || ab) begin
        m_active = 0;
        m_done   = 1;
        m_abort  = 0;
        m_plan.delete();
      end else begin
        if (m_first) m_duty = m_new_period;
        m_first = 0;
        m_ampl  = m_plan.pop_front();
        if (m_plan.size() == 0) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (ab) begin
      m_abort = 1;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge(rst, cfg_valid, abort, int'(cfg_target), int'(cfg_period), int'(cfg_step));
    cyc_n++;
    @(negedge clk);
    check("ampl",         ampl,         m_ampl);
    check("duty_cycle",   duty_cycle,   m_duty);
    check("cfg_ready",    cfg_ready,    !m_active);
    check("busy",         busy,         m_active);
    check("done",         done,         m_done);
    check("period_start", period_start, m_pcnt == 1);
    if (int'(ampl) != last_ampl) begin
      seen_v.push_back(int'(ampl));
      seen_t.push_back(cyc_n);
      last_ampl = int'(ampl);
    end
  endtask

  task automatic send(input int tgt, input int per, input int stp);
    cfg_target = XLEN'(tgt);
    cfg_period = (XLEN+1)'(per);
    cfg_step   = STEP_W'(stp);
    cfg_valid  = 1'b1;
    cyc();
    cfg_valid  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      cyc();
      n++;
    end
    checks++;
    assert (n < limit) else begin
      errors++;
      $error("FAIL %s timeout: waited=%0d limit=%0d", tag, n, limit);
    end
  endtask

  task automatic check_seq(input string tag, input int exp_v[$], input int gap);
    check({tag, "_len"}, seen_v.size(), exp_v.size());
    for (int i = 0; i < exp_v.size() && i < seen_v.size(); i++) begin
      check({tag, "_val"}, seen_v[i], exp_v[i]);
      if (i > 0) check({tag, "_gap"}, seen_t[i] - seen_t[i-1], gap);
    end
  endtask

  initial begin
    int n;
    int exp_q[$];
    rst = 1'b1; cfg_valid = 1'b0; cfg_target = '0; cfg_period = '0; cfg_step = '0; abort = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_ampl",    ampl,         0);
    check("rst_duty",    duty_cycle,   256);
    check("rst_ready",   cfg_ready,    1);
    check("rst_busy",    busy,         0);
    check("rst_pstart",  period_start, 1);
    check("rst_done",    done,         0);

    // Ramp up 0 -> 10, period 4, step 3
    seen_v.delete(); seen_t.delete();
    send(10, 4, 3);
    wait_done("up", 600);
    check("up_final_ampl", ampl, 10);
    check("up_final_duty", duty_cycle, 4);
    exp_q = '{3, 6, 9, 10};
    check_seq("up", exp_q, 4);

    // Ramp down 10 -> 0, step 4, no underflow
    cyc();
    seen_v.delete(); seen_t.delete();
    send(0, 4, 4);
    wait_done("down", 100);
    check("down_final_ampl", ampl, 0);
    exp_q = '{6, 2, 0};
    check_seq("down", exp_q, 4);

    // Zero period and zero step clamp to 1
    cyc();
    seen_v.delete(); seen_t.delete();
    send(2, 0, 0);
    wait_done("clamp", 100);
    check("clamp_duty", duty_cycle, 1);
    check("clamp_ampl", ampl, 2);
    exp_q = '{1, 2};
    check_seq("clamp", exp_q, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("clamp_pstart", period_start, 1);
    end

    // cfg_valid held across a ramp is taken in the done cycle
    send(20, 5, 1);
    cfg_target = 8'd5; cfg_period = 9'd3; cfg_step = 4'd2; cfg_valid = 1'b1;
    wait_done("hs_first", 300);
    check("hs_ready_at_done", cfg_ready, 1);
    check("hs_ampl_at_done", ampl, 20);
    cyc();
    cfg_valid = 1'b0;
    check("hs_accepted_busy", busy, 1);
    wait_done("hs_second", 200);
    check("hs_second_ampl", ampl, 5);
    check("hs_second_duty", duty_cycle, 3);

    // Abort during RAMP at ampl = 6
    cyc();
    send(30, 4, 1);
    n = 0;
    while (ampl !== 8'd6 && n < 50) begin cyc(); n++; end
    check("abort_reach6", n < 50, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    wait_done("abort", 50);
    check("abort_ampl", ampl, 6);
    check("abort_busy", busy, 0);
    for (int i = 0; i < 6; i++) cyc();
    check("abort_hold", ampl, 6);
    check("abort_idle", cfg_ready, 1);

    // Reset in the middle of a ramp
    send(200, 3, 1);
    n = 0;
    while (ampl < 8'd9 && n < 100) begin cyc(); n++; end
    check("midrst_progress", n < 100, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_ampl", ampl, 0);
    check("midrst_duty", duty_cycle, 256);
    check("midrst_ready", cfg_ready, 1);
    last_ampl = 0;

    // Random traffic checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      cfg_valid  = ($urandom_range(0, 7) == 0);
      cfg_target = XLEN'($urandom_range(0, 255));
      cfg_period = (XLEN+1)'($urandom_range(0, 6));
      cfg_step   = STEP_W'($urandom_range(0, 15));
      abort      = ($urandom_range(0, 39) == 0);
      rst        = ($urandom_range(0, 999) == 0);
      cyc();
    end
    rst = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
